// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//
// Signals:
//   imem_addr   fetch address (fetch stage -> memory)
//   imem_req    fetch request (fetch stage -> memory)
//   imem_rdata  instruction word, valid while imem_ready=1 (memory -> fetch stage)
//   imem_ready  memory has data for imem_addr this cycle (memory -> fetch stage)
//
// Modports:
//   master  the fetch stage side
//   slave   the instruction memory side
interface if_id_fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Front end of the 5-stage pipeline: owns the PC register and the IF/ID
// pipeline register. Honours the hazard unit's stall controls and the
// EX-stage branch flush, inserts NOP bubbles on flush or memory wait, and
// keeps saturating stall/flush performance counters.
//
// Ports:
//   clk            system clock, all state updates on rising edge
//   rst_n          synchronous active-low reset
//   pc_write       from hazard unit; 0 = hold PC
//   IF_ID_write    from hazard unit; 0 = hold IF/ID register
//   flush          branch/jump taken in EX; redirect and squash
//   branch_target  redirect address, used when flush=1 (low two bits ignored)
//   imem           instruction-memory bus (master side)
//   IF_ID_pc       PC of the instruction held in IF/ID
//   IF_ID_instr    instruction held in IF/ID
//   IF_ID_valid    1 = real instruction, 0 = bubble
//   stall_count    cycles held by hazard stall (saturating)
//   flush_count    number of flushes taken (saturating)
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pc_write,
  input  logic                 IF_ID_write,
  input  logic                 flush,
  input  logic [31:0]          branch_target,
  if_id_fetch_stage_if.master  imem,
  output logic [31:0]          IF_ID_pc,
  output logic [31:0]          IF_ID_instr,
  output logic                 IF_ID_valid,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  // What the stage does at the next rising edge, in priority order.
  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_WAIT,
    ACT_STALL,
    ACT_FLUSH
  } action_t;

  // Only the word-aligned part of the PC is stored, so the low two address
  // bits are zero by construction and pc+4 wraps naturally at 32 bits.
  logic [31:2] pc_q;
  logic        req_q;
  logic        stall;
  action_t     action;
  logic        unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  assign imem.imem_addr = {pc_q, 2'b00};
  assign imem.imem_req  = req_q;

  // Either hazard control going low freezes the whole stage, so PC and IF/ID
  // always move together and no instruction is duplicated or dropped.
  assign stall = ~pc_write | ~IF_ID_write;

  // While the request register is still low (first cycle out of reset) the
  // memory handshake is not consulted and a normal fetch is taken.
  always_comb begin
    action = ACT_FETCH;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (stall) begin
      action = ACT_STALL;
    end else if (req_q && !imem.imem_ready) begin
      action = ACT_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC[31:2];
      req_q       <= 1'b0;
      IF_ID_pc    <= 32'h0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      req_q <= 1'b1;
      case (action)
        ACT_FLUSH: begin
          pc_q        <= branch_target[31:2];
          IF_ID_pc    <= 32'h0;
          IF_ID_instr <= NOP_INSTR;
          IF_ID_valid <= 1'b0;
          if (flush_count != '1) begin
            flush_count <= flush_count + CNT_W'(1);
          end
        end
        ACT_STALL: begin
          if (stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
          end
        end
        ACT_WAIT: begin
          IF_ID_pc    <= 32'h0;
          IF_ID_instr <= NOP_INSTR;
          IF_ID_valid <= 1'b0;
        end
        default: begin
          IF_ID_pc    <= {pc_q, 2'b00};
          IF_ID_instr <= imem.imem_rdata;
          IF_ID_valid <= 1'b1;
          pc_q        <= pc_q + 30'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage. Each driven cycle updates a
// behavioural model of the stage and queues the expected post-edge state;
// a monitor compares the DUT against the queue after every rising edge.
module tb_if_id_fetch_stage;

  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pc_write;
  logic              IF_ID_write;
  logic              flush;
  logic [31:0]       branch_target;
  logic              ready;
  logic [31:0]       salt;
  logic [31:0]       IF_ID_pc;
  logic [31:0]       IF_ID_instr;
  logic              IF_ID_valid;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  int errors = 0;
  int checks = 0;

  if_id_fetch_stage_if bus();

  // Memory returns a word derived from the address it is asked for.
  assign bus.imem_rdata = bus.imem_addr ^ salt;
  assign bus.imem_ready = ready;

  if_id_fetch_stage #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .IF_ID_write   (IF_ID_write),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (bus),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_valid   (IF_ID_valid),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] instr;
    logic        valid;
    logic        req;
    int          sc;
    int          fc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_req;
  int          m_sc;
  int          m_fc;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("imem_addr", bus.imem_addr, e.pc);
    checkValue("imem_req", 32'(bus.imem_req), 32'(e.req));
    checkValue("IF_ID_pc", IF_ID_pc, e.if_pc);
    checkValue("IF_ID_instr", IF_ID_instr, e.instr);
    checkValue("IF_ID_valid", 32'(IF_ID_valid), 32'(e.valid));
    checkValue("stall_count", 32'(stall_count), e.sc);
    checkValue("flush_count", 32'(flush_count), e.fc);
  endtask

  // Drives one cycle's inputs, advances the model by one edge, queues the
  // expected state and waits until the edge has been taken.
  task automatic applyStimulus(input logic rn, input logic pw, input logic iw,
                               input logic fl, input logic [31:0] bt, input logic rdy);
    exp_t e;
    rst_n         = rn;
    pc_write      = pw;
    IF_ID_write   = iw;
    flush         = fl;
    branch_target = bt;
    ready         = rdy;
    if (!rn) begin
      m_pc = RST_PC; m_if_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_req = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (fl) begin
        m_pc = bt & 32'hFFFF_FFFC;
        m_if_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
        if (m_fc < CNT_MAX) m_fc++;
      end else if (!(pw && iw)) begin
        if (m_sc < CNT_MAX) m_sc++;
      end else if (m_req && !rdy) begin
        m_if_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      end else begin
        m_if_pc = m_pc;
        m_instr = m_pc ^ salt;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
      m_req = 1'b1;
    end
    e.pc = m_pc; e.if_pc = m_if_pc; e.instr = m_instr; e.valid = m_valid;
    e.req = m_req; e.sc = m_sc; e.fc = m_fc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every rising edge consumes one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
    branch_target = 32'h0; ready = 1'b1; salt = 32'h0;
    m_pc = RST_PC; m_if_pc = 0; m_instr = NOP; m_valid = 0; m_req = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);

    // Reset
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkValue("reset pc", bus.imem_addr, 32'h0);
    checkValue("reset req", 32'(bus.imem_req), 32'h0);
    checkValue("reset instr", IF_ID_instr, 32'h13);
    checkValue("reset valid", 32'(IF_ID_valid), 32'h0);

    // Free run, word = address; then a one-cycle load-use stall at IF/ID pc 0x4
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkValue("run IF_ID_pc", IF_ID_pc, 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("stall IF_ID_pc", IF_ID_pc, 32'h4);
    checkValue("stall pc", bus.imem_addr, 32'h8);
    checkValue("stall count", 32'(stall_count), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkValue("resume IF_ID_pc", IF_ID_pc, 32'h8);
    checkValue("resume instr", IF_ID_instr, 32'h8);
    checkValue("resume valid", 32'(IF_ID_valid), 32'h1);
    checkValue("resume pc", bus.imem_addr, 32'hC);

    // Flush during stall
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 1'b1);
    checkValue("flush pc", bus.imem_addr, 32'h100);
    checkValue("flush instr", IF_ID_instr, 32'h13);
    checkValue("flush valid", 32'(IF_ID_valid), 32'h0);
    checkValue("flush count", 32'(flush_count), 32'h1);
    checkValue("flush stall count", 32'(stall_count), 32'h1);

    // Memory wait at 0x20
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checkValue("wait valid", 32'(IF_ID_valid), 32'h0);
      checkValue("wait pc", bus.imem_addr, 32'h20);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkValue("ready IF_ID_pc", IF_ID_pc, 32'h20);
    checkValue("ready pc", bus.imem_addr, 32'h24);

    // PC wrap
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkValue("wrap pc", bus.imem_addr, 32'h0);
    checkValue("wrap IF_ID_pc", IF_ID_pc, 32'hFFFF_FFFC);

    // Stall counter saturation
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    end
    checkValue("stall saturate", 32'(stall_count), 32'hF);

    // Reset mid-stall
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    checkValue("mid reset req", 32'(bus.imem_req), 32'h0);
    checkValue("mid reset stall count", 32'(stall_count), 32'h0);
    checkValue("mid reset pc", bus.imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkValue("post reset req", 32'(bus.imem_req), 32'h1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic rn, pw, iw, fl, rdy;
      if (i % 97 == 0) salt = $urandom;
      rn  = ($urandom_range(0, 49) != 0);
      pw  = ($urandom_range(0, 7) != 0);
      iw  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(rn, pw, iw, fl, $urandom, rdy);
    end

    checkValue("queue drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
